// File: rtl/knn_pkg.sv
// Shared definitions for the kNN vote stage and its neighbours: the vote
// FSM state type, the systole empty-sentinel value and the neighbour
// countability rule.
package knn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    SELECT = 3'd2,
    TIEBRK = 3'd3,
    DONE   = 3'd4
  } vote_state_t;

  // All-ones value of a sum_len-bit sum; the systole uses it to mark an empty slot.
  function automatic logic [31:0] sum_sentinel(input int unsigned sum_len);
    logic [31:0] v;
    if (sum_len >= 32'd32) begin
      v = 32'hFFFF_FFFF;
    end else begin
      v = (32'd1 << sum_len) - 32'd1;
    end
    return v;
  endfunction

  // A neighbour votes only if its slot is filled and its label names a real class.
  function automatic logic is_countable(input logic [31:0] sum, input logic [31:0] lbl,
                                        input int unsigned sum_len, input int unsigned class_num);
    return (sum != sum_sentinel(sum_len)) && (lbl < class_num);
  endfunction

endpackage

// File: rtl/knn_vote_argmax.sv
// Sequential running-max scanner over the per-class vote counters.
// A start pulse arms the scan; one class is examined per cycle and done is
// raised in the cycle that examines the last class, with res_* already
// including that last comparison. Strict '>' keeps the lowest class on ties.
module knn_vote_argmax
  import knn_pkg::*;
#(
  parameter int CLASS_NUM = 4,
  parameter int CNT_W     = 3,
  parameter int LBL_LEN   = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CLASS_NUM-1:0][CNT_W-1:0]  cnt,
  output logic                             done,
  output logic [LBL_LEN-1:0]               res_lbl,
  output logic [CNT_W-1:0]                 res_cnt
);

  localparam int CIDX_W = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
  localparam logic [CIDX_W-1:0] LAST_C = CIDX_W'(CLASS_NUM - 1);

  logic              busy_q, busy_d;
  logic [CIDX_W-1:0] c_q, c_d;
  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic [CIDX_W-1:0] best_lbl_q, best_lbl_d;
  logic [CNT_W-1:0]  cur_cnt_s;
  logic [CNT_W-1:0]  nb_cnt_s;
  logic [CIDX_W-1:0] nb_lbl_s;

  // Compare the current class against the running best and advance the scan.
  always_comb begin
    cur_cnt_s  = cnt[c_q];
    busy_d     = busy_q;
    c_d        = c_q;
    best_cnt_d = best_cnt_q;
    best_lbl_d = best_lbl_q;
    if (busy_q && (cur_cnt_s > best_cnt_q)) begin
      nb_cnt_s = cur_cnt_s;
      nb_lbl_s = c_q;
    end else begin
      nb_cnt_s = best_cnt_q;
      nb_lbl_s = best_lbl_q;
    end
    done    = busy_q && (c_q == LAST_C);
    res_cnt = nb_cnt_s;
    res_lbl = LBL_LEN'(nb_lbl_s);
    if (start) begin
      busy_d     = 1'b1;
      c_d        = '0;
      best_cnt_d = '0;
      best_lbl_d = '0;
    end else if (busy_q) begin
      busy_d     = !done;
      c_d        = c_q + CIDX_W'(1);
      best_cnt_d = nb_cnt_s;
      best_lbl_d = nb_lbl_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Scanner state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      c_q        <= '0;
      best_cnt_q <= '0;
      best_lbl_q <= '0;
    end else begin
      busy_q     <= busy_d;
      c_q        <= c_d;
      best_cnt_q <= best_cnt_d;
      best_lbl_q <= best_lbl_d;
    end
  end

endmodule

// File: rtl/knn_vote.sv
// kNN majority-vote stage: captures the K nearest (sum, label) pairs,
// counts votes per class one neighbour per cycle, scans for the winner and
// emits one registered result with a single-cycle out_valid strobe.
// Optional macro KNN_VOTE_TIEBRK_EN: resolve equal maxima in favour of the
// class held by the nearest countable neighbour (adds K_NUM cycles).
module knn_vote
  import knn_pkg::*;
#(
  parameter int SUM_LEN   = 10,
  parameter int LBL_LEN   = 10,
  parameter int K_NUM     = 5,
  parameter int CLASS_NUM = 4,
  parameter int CNT_W     = $clog2(K_NUM + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [K_NUM-1:0][SUM_LEN-1:0]  inS,
  input  logic [K_NUM-1:0][LBL_LEN-1:0]  inL,
  output logic                           out_valid,
  output logic [LBL_LEN-1:0]             out_lbl,
  output logic [CNT_W-1:0]               out_votes,
  output logic                           out_empty
);

  localparam int IDX_W = (K_NUM > 1) ? $clog2(K_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K_NUM - 1);

  vote_state_t                     state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [K_NUM-1:0][SUM_LEN-1:0]   ins_q, ins_d;
  logic [K_NUM-1:0][LBL_LEN-1:0]   inl_q, inl_d;
  logic [CLASS_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic [LBL_LEN-1:0]              out_lbl_q, out_lbl_d;
  logic [CNT_W-1:0]                out_votes_q, out_votes_d;
  logic                            out_empty_q, out_empty_d;

  logic [SUM_LEN-1:0]              cur_sum_s;
  logic [LBL_LEN-1:0]              cur_lbl_s;
  logic                            cur_ok_s;
  logic                            am_start_s;
  logic                            am_done_s;
  logic [LBL_LEN-1:0]              am_lbl_s;
  logic [CNT_W-1:0]                am_cnt_s;

`ifdef KNN_VOTE_TIEBRK_EN
  logic [LBL_LEN-1:0]              tb_best_lbl_q, tb_best_lbl_d;
  logic [CNT_W-1:0]                tb_best_cnt_q, tb_best_cnt_d;
  logic                            tb_found_q, tb_found_d;
  logic [LBL_LEN-1:0]              tb_lbl_q, tb_lbl_d;
  logic [CNT_W-1:0]                cur_cnt_s;
`endif

  knn_vote_argmax #(
    .CLASS_NUM (CLASS_NUM),
    .CNT_W     (CNT_W),
    .LBL_LEN   (LBL_LEN)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .start   (am_start_s),
    .cnt     (cnt_q),
    .done    (am_done_s),
    .res_lbl (am_lbl_s),
    .res_cnt (am_cnt_s)
  );

  // Vote FSM: capture, count, select (and optionally tie-break), then publish.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ins_d       = ins_q;
    inl_d       = inl_q;
    cnt_d       = cnt_q;
    out_lbl_d   = out_lbl_q;
    out_votes_d = out_votes_q;
    out_empty_d = out_empty_q;
    am_start_s  = 1'b0;
    cur_sum_s   = ins_q[idx_q];
    cur_lbl_s   = inl_q[idx_q];
    cur_ok_s    = is_countable(32'(cur_sum_s), 32'(cur_lbl_s), SUM_LEN, CLASS_NUM);
`ifdef KNN_VOTE_TIEBRK_EN
    tb_best_lbl_d = tb_best_lbl_q;
    tb_best_cnt_d = tb_best_cnt_q;
    tb_found_d    = tb_found_q;
    tb_lbl_d      = tb_lbl_q;
    cur_cnt_s     = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      if (cur_lbl_s == LBL_LEN'(c)) begin
        cur_cnt_s = cnt_q[c];
      end else begin
        cur_cnt_s = cur_cnt_s;
      end
    end
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ins_d   = inS;
          inl_d   = inL;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        for (int c = 0; c < CLASS_NUM; c++) begin
          if (cur_ok_s && (cur_lbl_s == LBL_LEN'(c))) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end else begin
            cnt_d[c] = cnt_q[c];
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          am_start_s = 1'b1;
          state_d    = SELECT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SELECT: begin
        if (am_done_s) begin
`ifdef KNN_VOTE_TIEBRK_EN
          tb_best_lbl_d = am_lbl_s;
          tb_best_cnt_d = am_cnt_s;
          tb_found_d    = 1'b0;
          tb_lbl_d      = '0;
          idx_d         = '0;
          state_d       = TIEBRK;
`else
          out_votes_d = am_cnt_s;
          out_empty_d = (am_cnt_s == '0);
          if (am_cnt_s == '0) begin
            out_lbl_d = '0;
          end else begin
            out_lbl_d = am_lbl_s;
          end
          state_d = DONE;
`endif
        end else begin
          state_d = SELECT;
        end
      end
      TIEBRK: begin
`ifdef KNN_VOTE_TIEBRK_EN
        // First (nearest) countable neighbour whose class reached the maximum wins.
        if (!tb_found_q && cur_ok_s && (cur_cnt_s == tb_best_cnt_q)) begin
          tb_found_d = 1'b1;
          tb_lbl_d   = cur_lbl_s;
        end else begin
          tb_found_d = tb_found_q;
        end
        if (idx_q == LAST_IDX) begin
          out_votes_d = tb_best_cnt_q;
          out_empty_d = (tb_best_cnt_q == '0);
          if (tb_best_cnt_q == '0) begin
            out_lbl_d = '0;
          end else if (tb_found_d) begin
            out_lbl_d = tb_lbl_d;
          end else begin
            out_lbl_d = tb_best_lbl_q;
          end
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = TIEBRK;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, captured neighbour set, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ins_q       <= '0;
      inl_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_lbl_q   <= '0;
      out_votes_q <= '0;
      out_empty_q <= 1'b0;
`ifdef KNN_VOTE_TIEBRK_EN
      tb_best_lbl_q <= '0;
      tb_best_cnt_q <= '0;
      tb_found_q    <= 1'b0;
      tb_lbl_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ins_q       <= ins_d;
      inl_q       <= inl_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_lbl_q   <= out_lbl_d;
      out_votes_q <= out_votes_d;
      out_empty_q <= out_empty_d;
`ifdef KNN_VOTE_TIEBRK_EN
      tb_best_lbl_q <= tb_best_lbl_d;
      tb_best_cnt_q <= tb_best_cnt_d;
      tb_found_q    <= tb_found_d;
      tb_lbl_q      <= tb_lbl_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_lbl   = out_lbl_q;
  assign out_votes = out_votes_q;
  assign out_empty = out_empty_q;

endmodule
